// File: rtl/wb_grf_pkg.sv
// Shared decode constants for the P6 pipeline decoders and the write-back stage.
package wb_grf_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Function codes for OP_RTYPE (instr[5:0])
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // Source of the value written back to the register file
    typedef enum logic [2:0] {
        WB_ALU,
        WB_MEM,
        WB_EXT,
        WB_PC8,
        WB_MD
    } wb_src_e;

    // Load width/signedness seen by the load extender
    typedef enum logic [2:0] {
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_type_e;

endpackage

// File: rtl/wb_load_ext.sv
// Byte/halfword lane select and sign/zero extension of the raw DM word.
module wb_load_ext
    import wb_grf_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [1:0]  i_boff,
    input  ld_type_e    i_ld,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the word
    always_comb begin
        w_byte = i_rd[7:0];
        case (i_boff)
            2'd0:    w_byte = i_rd[7:0];
            2'd1:    w_byte = i_rd[15:8];
            2'd2:    w_byte = i_rd[23:16];
            default: w_byte = i_rd[31:24];
        endcase
        w_half = i_boff[1] ? i_rd[31:16] : i_rd[15:0];
    end

    // Extend the selected lane according to the load type
    always_comb begin
        o_data = i_rd;
        case (i_ld)
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'd0, w_byte};
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rd;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// W-stage write-back: destination/data decode, 32x32 register file with
// W->D bypass on both read ports, and a registered commit trace.
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int          NREG     = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_W,
    input  logic [31:0] pc_W,
    input  logic [31:0] pc_W8,
    input  logic [31:0] aluRet_W,
    input  logic [31:0] RD_W,
    input  logic [31:0] ext_W,
    input  logic [31:0] mdOut_W,
    input  logic [4:0]  ra1_D,
    input  logic [4:0]  ra2_D,
    output logic [31:0] rd1_D,
    output logic [31:0] rd2_D,
    output logic        we_W,
    output logic [4:0]  waddr_W,
    output logic [31:0] wdata_W,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dst;
    wb_src_e     w_src;
    ld_type_e    w_ld;
    logic [31:0] w_ld_data;
    logic        w_unused_ok;

    logic [31:0] r_grf [NREG];

    assign w_op    = instr_W[31:26];
    assign w_funct = instr_W[5:0];
    assign w_rt    = instr_W[20:16];
    assign w_rd    = instr_W[15:11];

    // rs and shamt play no part in write-back
    assign w_unused_ok = ^{instr_W[25:21], instr_W[10:6]};

    // Decode destination register, write-back source and load type
    always_comb begin
        w_dst = 5'd0;
        w_src = WB_ALU;
        w_ld  = LD_W;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU,
                    F_SLL, F_SRL, F_SRA: w_dst = w_rd;
                    F_JALR: begin
                        w_dst = w_rd;
                        w_src = WB_PC8;
                    end
                    F_MFHI, F_MFLO: begin
                        w_dst = w_rd;
                        w_src = WB_MD;
                    end
                    default: w_dst = 5'd0;
                endcase
            end
            OP_ORI, OP_ANDI, OP_ADDI, OP_ADDIU, OP_SLTI: w_dst = w_rt;
            OP_LUI: begin
                w_dst = w_rt;
                w_src = WB_EXT;
            end
            OP_LW: begin
                w_dst = w_rt;
                w_src = WB_MEM;
                w_ld  = LD_W;
            end
            OP_LB: begin
                w_dst = w_rt;
                w_src = WB_MEM;
                w_ld  = LD_B;
            end
            OP_LBU: begin
                w_dst = w_rt;
                w_src = WB_MEM;
                w_ld  = LD_BU;
            end
            OP_LH: begin
                w_dst = w_rt;
                w_src = WB_MEM;
                w_ld  = LD_H;
            end
            OP_LHU: begin
                w_dst = w_rt;
                w_src = WB_MEM;
                w_ld  = LD_HU;
            end
            OP_JAL: begin
                w_dst = REG_RA;
                w_src = WB_PC8;
            end
            default: w_dst = 5'd0;
        endcase
    end

    wb_load_ext u_load_ext (
        .i_rd   (RD_W),
        .i_boff (aluRet_W[1:0]),
        .i_ld   (w_ld),
        .o_data (w_ld_data)
    );

    // Select the write-back data; an rd/rt of $0 naturally yields no write
    always_comb begin
        wdata_W = aluRet_W;
        case (w_src)
            WB_MEM:  wdata_W = w_ld_data;
            WB_EXT:  wdata_W = ext_W;
            WB_PC8:  wdata_W = pc_W8;
            WB_MD:   wdata_W = mdOut_W;
            default: wdata_W = aluRet_W;
        endcase
    end

    assign waddr_W = w_dst;
    assign we_W    = (w_dst != 5'd0);

    // Commit the write-back result; reset clears every entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= 32'd0;
            end
        end else if (we_W) begin
            r_grf[waddr_W] <= wdata_W;
        end
    end

    // Read ports: $0 is zero, a same-cycle W write wins over the array
    always_comb begin
        if (ra1_D == 5'd0) begin
            rd1_D = 32'd0;
        end else if (we_W && (ra1_D == waddr_W)) begin
            rd1_D = wdata_W;
        end else begin
            rd1_D = r_grf[ra1_D];
        end

        if (ra2_D == 5'd0) begin
            rd2_D = 32'd0;
        end else if (we_W && (ra2_D == waddr_W)) begin
            rd2_D = wdata_W;
        end else begin
            rd2_D = r_grf[ra2_D];
        end
    end

    // Trace of the last committed write; payload holds until the next write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= PC_RESET;
            trace_addr  <= 5'd0;
            trace_data  <= 32'd0;
        end else begin
            trace_valid <= we_W;
            if (we_W) begin
                trace_pc   <= pc_W;
                trace_addr <= waddr_W;
                trace_data <= wdata_W;
            end
        end
    end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Consumer end of the MEM/WB pipeline register in the P6 five-stage MIPS core.
- Takes the W-stage bundle (instr_W, pc_W8, aluRet_W, RD_W, ext_W, mdOut_W) and decodes the destination register and write-back data.
- Applies load-data extension, then commits the result to the 32x32 general register file.
- Serves the two D-stage read ports with same-cycle W→D internal bypass, and exports the W-stage write tuple for the hazard/forwarding unit.

Parameters:
- NREG, 32, number of architectural registers; $0 is hard-wired to zero.
- PC_RESET, 32'h00003000, reset PC value; used only by the trace output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all GRF entries.
- instr_W  in  32  instruction in W stage.
- pc_W  in  32  PC of the W instruction.
- pc_W8  in  32  PC+8, link value.
- aluRet_W  in  32  ALU result, also the load address.
- RD_W  in  32  raw word read from DM.
- ext_W  in  32  extended immediate; the lui value.
- mdOut_W  in  32  HI/LO read value.
- ra1_D  in  5  read address, port 1.
- ra2_D  in  5  read address, port 2.
- rd1_D  out  32  read data, port 1.
- rd2_D  out  32  read data, port 2.
- we_W  out  1  W stage writes a nonzero register this cycle.
- waddr_W  out  5  destination register; 0 when no write.
- wdata_W  out  32  write-back data, for forwarding.
- trace_valid  out  1  registered: a write committed last cycle.
- trace_pc  out  32  registered: pc_W of the committed write.
- trace_addr  out  5  registered: destination of the committed write.
- trace_data  out  32  registered: data of the committed write.

Behaviour:
- Decode uses op = instr_W[31:26], funct = instr_W[5:0], rt = [20:16], rd = [15:11].
- Destination register:
  - op=000000 with funct addu/subu/and/or/slt/sltu/sll/srl/sra/jalr/mfhi/mflo → rd.
  - ori/andi/addi/addiu/slti/lui/lw/lb/lbu/lh/lhu → rt.
  - jal → 31.
  - Everything else (stores, branches, j, jr, mult/div/mthi/mtlo, nop, unknown) → 0.
- Write-data source:
  - Loads → extended RD_W.
  - lui → ext_W.
  - jal/jalr → pc_W8.
  - mfhi/mflo → mdOut_W.
  - Otherwise → aluRet_W.
- Load extension, with byte offset b = aluRet_W[1:0]:
  - lb/lbu: select byte b (b=0 → RD_W[7:0]), then sign- or zero-extend.
  - lh/lhu: select half b[1] (b[1]=0 → RD_W[15:0]), then sign- or zero-extend.
  - lw: RD_W unchanged.
  - Misaligned accesses are not checked here.
- Write enable: we_W = (waddr_W != 0). A write to $0 is suppressed and waddr_W is forced to 0.
- The GRF writes on the rising clk edge when we_W=1.
- Reads are combinational. If raX_D == waddr_W and we_W=1, rdX_D = wdata_W (internal bypass); otherwise rdX_D = GRF[raX_D]. Address 0 always reads 0.
- Trace registers:
  - Update every edge: trace_valid <= we_W; the remaining fields latch only when we_W=1.
  - trace_pc <= pc_W. Its reset value is PC_RESET.
- Reset (reset=0, asynchronous):
  - All GRF entries become 0; trace_valid=0, trace_addr=0, trace_data=0, trace_pc=PC_RESET.
  - A reset asserted during a write cycle drops that write.
- Both read ports may address the same register, including the bypassed one; both then return the identical value.
- Reset bubble: the M/W register clears instr_W to 0 (an sll $0 nop), which decodes to waddr 0 and no write.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, …
  - funct constants: F_JALR, F_MFHI, F_MFLO, …
  - write-source enumeration: WB_ALU, WB_MEM, WB_EXT, WB_PC8, WB_MD.
- The D/E/M-stage decoders reuse the same package.
- Sub-module: wb_load_ext, a combinational byte/half select-and-extend from (RD_W, aluRet_W[1:0], load type) to 32-bit data.
- Decode and the GRF array stay in the top module.

Test Plan:
- Reset low mid-run, after writing $5=32'h1234 → rd1_D(ra1=5)=0 at once, trace_valid=0, trace_pc=32'h00003000.
- ori $8,$0,0x00ff with aluRet_W=32'h00ff → we_W=1, waddr_W=8; next cycle ra1=8 reads 32'h000000ff, and trace_addr=8, trace_data=32'hff.
- lb $9 with RD_W=32'h80FF7F01 and aluRet[1:0]=3 → 32'hFFFFFF80. Same stimulus with lbu → 32'h80. lh at offset 2 → 32'hFFFF80FF.
- jal at pc_W=32'h3010 (pc_W8=32'h3018) with ra1_D=31 in the same cycle → rd1_D=32'h3018 via bypass; $31 holds 32'h3018 afterwards.
- addu with rd=0 and aluRet=32'hDEADBEEF → we_W=0, waddr_W=0; $0 reads 0; trace_valid=0.
- sw/beq/mult/nop sequence → no GRF change, we_W=0 every cycle. Then mflo $3 with mdOut_W=7 → $3=7.
